// File: rtl/joe_anim_ctrl.sv
// Sprite animation controller for Joe: pose FSM, run-frame phasing, clamped
// horizontal motion, knock-back flight and post-hit blinking immunity.
module joe_anim_ctrl #(
    parameter int unsigned RUN_STEP   = 6,
    parameter int unsigned RUN_SPEED  = 3,
    parameter int unsigned FLY_SPEED  = 4,
    parameter int unsigned FLY_FRAMES = 30,
    parameter int unsigned INV_FRAMES = 60,
    parameter int unsigned X_MIN      = 45,
    parameter int unsigned X_MAX      = 594,
    parameter int unsigned X_INIT     = 320,
    parameter int unsigned Y_INIT     = 400
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_warm,
    input  logic       key_go,
    input  logic [1:0] hit_in,
    output logic [9:0] centerx,
    output logic [9:0] centery,
    output logic [1:0] joe_run_left,
    output logic [1:0] joe_run_right,
    output logic       right_hand_warm,
    output logic       left_hand_go,
    output logic       stand,
    output logic [1:0] hit_joe,
    output logic       show_joe
);

    localparam int unsigned STEP_W = (RUN_STEP > 1) ? $clog2(RUN_STEP) : 1;
    localparam int unsigned FLY_W  = (FLY_FRAMES > 1) ? $clog2(FLY_FRAMES) : 1;
    localparam int unsigned INV_W  = $clog2(INV_FRAMES + 1) > 0 ? $clog2(INV_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        ST_STAND,
        ST_RUN_L,
        ST_RUN_R,
        ST_WARM,
        ST_GO,
        ST_FLY
    } state_t;

    state_t            state, state_n;
    logic [STEP_W-1:0] step_cnt, step_n;
    logic [1:0]        phase, phase_n;
    logic [FLY_W-1:0]  fly_cnt, fly_n;
    logic [INV_W-1:0]  inv_cnt, inv_n;
    logic [1:0]        blink_cnt, blink_n;
    logic [9:0]        x_n;
    logic [1:0]        hit_n;
    logic              show_n;
    logic [1:0]        run_l_n, run_r_n;
    logic              warm_n, go_n, stand_n;
    logic              hit_valid;

    // Leftward move at 11 bits, clamped to X_MIN without wrapping
    function automatic logic [9:0] move_dn(input logic [9:0] x, input int unsigned d);
        logic [10:0] xe;
        xe = {1'b0, x};
        if (xe < 11'(X_MIN + d)) move_dn = 10'(X_MIN);
        else                     move_dn = 10'(xe - 11'(d));
    endfunction

    // Rightward move at 11 bits, clamped to X_MAX
    function automatic logic [9:0] move_up(input logic [9:0] x, input int unsigned d);
        logic [10:0] sum;
        sum = {1'b0, x} + 11'(d);
        if (sum > 11'(X_MAX)) move_up = 10'(X_MAX);
        else                  move_up = sum[9:0];
    endfunction

    // State and output registers; everything advances only on frame ticks
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= ST_STAND;
            step_cnt        <= '0;
            phase           <= 2'd0;
            fly_cnt         <= '0;
            inv_cnt         <= '0;
            blink_cnt       <= 2'd0;
            centerx         <= 10'(X_INIT);
            centery         <= 10'(Y_INIT);
            joe_run_left    <= 2'd0;
            joe_run_right   <= 2'd0;
            right_hand_warm <= 1'b0;
            left_hand_go    <= 1'b0;
            stand           <= 1'b1;
            hit_joe         <= 2'b00;
            show_joe        <= 1'b1;
        end else if (frame_tick) begin
            state           <= state_n;
            step_cnt        <= step_n;
            phase           <= phase_n;
            fly_cnt         <= fly_n;
            inv_cnt         <= inv_n;
            blink_cnt       <= blink_n;
            centerx         <= x_n;
            joe_run_left    <= run_l_n;
            joe_run_right   <= run_r_n;
            right_hand_warm <= warm_n;
            left_hand_go    <= go_n;
            stand           <= stand_n;
            hit_joe         <= hit_n;
            show_joe        <= show_n;
        end
    end

    // Next-state, counters, motion and output decode
    always_comb begin
        state_n   = state;
        step_n    = step_cnt;
        phase_n   = phase;
        fly_n     = fly_cnt;
        inv_n     = inv_cnt;
        blink_n   = blink_cnt;
        hit_n     = hit_joe;
        show_n    = show_joe;
        x_n       = centerx;
        hit_valid = (hit_in == 2'b01) || (hit_in == 2'b10);

        if (state == ST_FLY) begin
            if (fly_cnt == FLY_W'(FLY_FRAMES - 1)) begin
                state_n = ST_STAND;
                inv_n   = INV_W'(INV_FRAMES);
                blink_n = 2'd0;
                show_n  = 1'(INV_FRAMES == 0);
                hit_n   = 2'b00;
            end else begin
                fly_n = fly_cnt + FLY_W'(1);
            end
        end else begin
            // Blink runs four ticks per level and ends visible
            if (inv_cnt != '0) begin
                inv_n = inv_cnt - INV_W'(1);
                if (inv_cnt == INV_W'(1)) begin
                    show_n  = 1'b1;
                    blink_n = 2'd0;
                end else begin
                    blink_n = blink_cnt + 2'd1;
                    if (blink_cnt == 2'd3) show_n = ~show_joe;
                end
            end

            if (hit_valid && (inv_cnt == '0)) begin
                state_n = ST_FLY;
                hit_n   = hit_in;
                fly_n   = '0;
            end else if (key_warm) begin
                state_n = ST_WARM;
            end else if (key_go) begin
                state_n = ST_GO;
            end else if (key_left && !key_right) begin
                state_n = ST_RUN_L;
            end else if (key_right && !key_left) begin
                state_n = ST_RUN_R;
            end else begin
                state_n = ST_STAND;
            end
        end

        // Fresh entry (including a direct direction swap) restarts the phase
        if ((state_n == ST_RUN_L) || (state_n == ST_RUN_R)) begin
            if (state_n != state) begin
                phase_n = 2'd1;
                step_n  = '0;
            end else if (step_cnt == STEP_W'(RUN_STEP - 1)) begin
                step_n  = '0;
                phase_n = (phase == 2'd1) ? 2'd2 : 2'd1;
            end else begin
                step_n = step_cnt + STEP_W'(1);
            end
        end

        case (state_n)
            ST_RUN_L: x_n = move_dn(centerx, RUN_SPEED);
            ST_RUN_R: x_n = move_up(centerx, RUN_SPEED);
            ST_FLY: begin
                if (hit_n == 2'b01)      x_n = move_up(centerx, FLY_SPEED);
                else if (hit_n == 2'b10) x_n = move_dn(centerx, FLY_SPEED);
            end
            default: x_n = centerx;
        endcase

        run_l_n = (state_n == ST_RUN_L) ? phase_n : 2'd0;
        run_r_n = (state_n == ST_RUN_R) ? phase_n : 2'd0;
        warm_n  = (state_n == ST_WARM);
        go_n    = (state_n == ST_GO);
        stand_n = (state_n == ST_STAND) || (state_n == ST_WARM) || (state_n == ST_GO);
    end

endmodule

// File: tb/tb_joe_anim_ctrl.sv
// Directed bench for joe_anim_ctrl: reset, running, edge clamping, key
// priorities, knock-back flight with blinking immunity, and async reset abort.
module tb_joe_anim_ctrl;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic       key_left, key_right, key_warm, key_go;
    logic [1:0] hit_in;
    logic [9:0] centerx, centery;
    logic [1:0] joe_run_left, joe_run_right, hit_joe;
    logic       right_hand_warm, left_hand_go, stand, show_joe;

    int vectors     = 0;
    int miscompares = 0;

    joe_anim_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_tick     (frame_tick),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_warm       (key_warm),
        .key_go         (key_go),
        .hit_in         (hit_in),
        .centerx        (centerx),
        .centery        (centery),
        .joe_run_left   (joe_run_left),
        .joe_run_right  (joe_run_right),
        .right_hand_warm(right_hand_warm),
        .left_hand_go   (left_hand_go),
        .stand          (stand),
        .hit_joe        (hit_joe),
        .show_joe       (show_joe)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_keys();
        key_left  = 1'b0;
        key_right = 1'b0;
        key_warm  = 1'b0;
        key_go    = 1'b0;
        hit_in    = 2'b00;
    endtask

    // One-cycle tick; returns on the following falling edge with outputs settled
    task automatic tick();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        clear_keys();
        frame_tick = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        clear_keys();
        frame_tick = 1'b0;
        Reset = 1'b0;
        #2 Reset = 1'b1;
        #1;
        vectors++; if (centerx !== 10'd320) begin miscompares++; $display("FAIL reset_centerx got %0d exp 320", centerx); end
        vectors++; if (centery !== 10'd400) begin miscompares++; $display("FAIL reset_centery got %0d exp 400", centery); end
        vectors++; if ({joe_run_left, joe_run_right} !== 4'b0000) begin miscompares++; $display("FAIL reset_run got %b exp 0000", {joe_run_left, joe_run_right}); end
        vectors++; if ({right_hand_warm, left_hand_go, stand} !== 3'b001) begin miscompares++; $display("FAIL reset_pose got %b exp 001", {right_hand_warm, left_hand_go, stand}); end
        vectors++; if ({hit_joe, show_joe} !== 3'b001) begin miscompares++; $display("FAIL reset_hit_show got %b exp 001", {hit_joe, show_joe}); end
        // A tick during reset must not move anything
        key_right  = 1'b1;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        vectors++; if ({centerx, stand} !== {10'd320, 1'b1}) begin miscompares++; $display("FAIL reset_tick_held got x=%0d stand=%b exp x=320 stand=1", centerx, stand); end
        @(negedge Clk) Reset = 1'b0;
        // No tick: keys alone must not change outputs
        repeat (3) @(negedge Clk);
        vectors++; if ({centerx, joe_run_right} !== {10'd320, 2'd0}) begin miscompares++; $display("FAIL no_tick_hold got x=%0d rr=%0d exp x=320 rr=0", centerx, joe_run_right); end
        clear_keys();
    endtask

    task automatic test_run_right();
        key_right = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            logic [1:0] ep;
            tick();
            ep = ((((i - 1) / 6) % 2) == 0) ? 2'd1 : 2'd2;
            vectors++; if (joe_run_right !== ep) begin miscompares++; $display("FAIL run_r_phase tick %0d got %0d exp %0d", i, joe_run_right, ep); end
            vectors++; if (centerx !== 10'(320 + 3 * i)) begin miscompares++; $display("FAIL run_r_x tick %0d got %0d exp %0d", i, centerx, 320 + 3 * i); end
            vectors++; if ({joe_run_left, stand} !== 3'b000) begin miscompares++; $display("FAIL run_r_pose tick %0d got rl=%0d stand=%b exp 0 0", i, joe_run_left, stand); end
        end
        vectors++; if (centerx !== 10'd359) begin miscompares++; $display("FAIL run_r_final got %0d exp 359", centerx); end
        clear_keys();
    endtask

    task automatic test_clamp_left();
        apply_reset();
        key_left = 1'b1;
        // 320-3*91 = 47; the next step would land at 44 and clamps to 45
        for (int i = 1; i <= 96; i++) begin
            int         ex;
            logic [1:0] ep;
            tick();
            ex = 320 - 3 * i;
            if (ex < 45) ex = 45;
            ep = ((((i - 1) / 6) % 2) == 0) ? 2'd1 : 2'd2;
            vectors++; if (centerx !== 10'(ex)) begin miscompares++; $display("FAIL clamp_l_x tick %0d got %0d exp %0d", i, centerx, ex); end
            vectors++; if ({joe_run_left, joe_run_right} !== {ep, 2'd0}) begin miscompares++; $display("FAIL clamp_l_run tick %0d got %0d/%0d exp %0d/0", i, joe_run_left, joe_run_right, ep); end
        end
        clear_keys();
    endtask

    task automatic test_key_priority();
        apply_reset();
        key_left = 1'b1; key_right = 1'b1;
        tick();
        vectors++; if ({stand, joe_run_left, joe_run_right, centerx} !== {1'b1, 2'd0, 2'd0, 10'd320}) begin miscompares++; $display("FAIL both_lr got stand=%b rl=%0d rr=%0d x=%0d exp 1 0 0 320", stand, joe_run_left, joe_run_right, centerx); end
        key_warm = 1'b1; key_go = 1'b1;
        tick();
        vectors++; if ({right_hand_warm, left_hand_go, stand} !== 3'b101) begin miscompares++; $display("FAIL warm_go got %b exp 101", {right_hand_warm, left_hand_go, stand}); end
        key_warm = 1'b0;
        tick();
        vectors++; if ({right_hand_warm, left_hand_go, stand} !== 3'b011) begin miscompares++; $display("FAIL go_only got %b exp 011", {right_hand_warm, left_hand_go, stand}); end
        key_go = 1'b0; hit_in = 2'b11;
        tick();
        vectors++; if ({hit_joe, stand, centerx} !== {2'b00, 1'b1, 10'd320}) begin miscompares++; $display("FAIL hit11_ignored got hit=%b stand=%b x=%0d exp 00 1 320", hit_joe, stand, centerx); end
        key_right = 1'b0;
        repeat (7) tick();
        vectors++; if ({joe_run_left, centerx} !== {2'd2, 10'd299}) begin miscompares++; $display("FAIL run_l_7 got rl=%0d x=%0d exp 2 299", joe_run_left, centerx); end
        key_left = 1'b0; key_right = 1'b1;
        tick();
        vectors++; if ({joe_run_left, joe_run_right, centerx} !== {2'd0, 2'd1, 10'd302}) begin miscompares++; $display("FAIL swap_lr got rl=%0d rr=%0d x=%0d exp 0 1 302", joe_run_left, joe_run_right, centerx); end
        clear_keys();
    endtask

    task automatic test_fly_immunity();
        apply_reset();
        key_warm = 1'b1; hit_in = 2'b10;
        tick();
        vectors++; if ({hit_joe, right_hand_warm, stand, show_joe} !== 5'b10001) begin miscompares++; $display("FAIL fly_entry got %b exp 10001", {hit_joe, right_hand_warm, stand, show_joe}); end
        vectors++; if (centerx !== 10'd316) begin miscompares++; $display("FAIL fly_entry_x got %0d exp 316", centerx); end
        key_right = 1'b1; hit_in = 2'b01;
        for (int i = 2; i <= 30; i++) begin
            tick();
            vectors++; if (centerx !== 10'(320 - 4 * i)) begin miscompares++; $display("FAIL fly_x tick %0d got %0d exp %0d", i, centerx, 320 - 4 * i); end
            vectors++; if ({hit_joe, stand, joe_run_right, right_hand_warm} !== 6'b100000) begin miscompares++; $display("FAIL fly_hold tick %0d got %b exp 100000", i, {hit_joe, stand, joe_run_right, right_hand_warm}); end
        end
        clear_keys();
        tick();
        vectors++; if ({stand, hit_joe, show_joe, centerx} !== {1'b1, 2'b00, 1'b0, 10'd200}) begin miscompares++; $display("FAIL fly_exit got stand=%b hit=%b show=%b x=%0d exp 1 00 0 200", stand, hit_joe, show_joe, centerx); end
        for (int j = 1; j <= 60; j++) begin
            logic es;
            if (j >= 10) hit_in = 2'b01;
            tick();
            es = (j == 60) ? 1'b1 : 1'((j / 4) % 2);
            vectors++; if (show_joe !== es) begin miscompares++; $display("FAIL blink j %0d got %b exp %b", j, show_joe, es); end
            vectors++; if ({hit_joe, stand, centerx} !== {2'b00, 1'b1, 10'd200}) begin miscompares++; $display("FAIL immune j %0d got hit=%b stand=%b x=%0d exp 00 1 200", j, hit_joe, stand, centerx); end
        end
        tick();
        vectors++; if ({hit_joe, stand, centerx} !== {2'b01, 1'b0, 10'd204}) begin miscompares++; $display("FAIL hit_after_immunity got hit=%b stand=%b x=%0d exp 01 0 204", hit_joe, stand, centerx); end
        clear_keys();
    endtask

    task automatic test_reset_mid_fly();
        repeat (2) tick();
        vectors++; if (centerx !== 10'd212) begin miscompares++; $display("FAIL pre_abort_x got %0d exp 212", centerx); end
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        vectors++; if ({centerx, centery} !== {10'd320, 10'd400}) begin miscompares++; $display("FAIL abort_xy got %0d,%0d exp 320,400", centerx, centery); end
        vectors++; if ({joe_run_left, joe_run_right, right_hand_warm, left_hand_go, stand, hit_joe, show_joe} !== 10'b0000_0010_01) begin miscompares++; $display("FAIL abort_outs got %b exp 0000001001", {joe_run_left, joe_run_right, right_hand_warm, left_hand_go, stand, hit_joe, show_joe}); end
        @(negedge Clk) Reset = 1'b0;
        tick();
        vectors++; if ({stand, hit_joe, show_joe, centerx} !== {1'b1, 2'b00, 1'b1, 10'd320}) begin miscompares++; $display("FAIL post_release got stand=%b hit=%b show=%b x=%0d exp 1 00 1 320", stand, hit_joe, show_joe, centerx); end
        hit_in = 2'b10;
        tick();
        vectors++; if ({hit_joe, centerx} !== {2'b10, 10'd316}) begin miscompares++; $display("FAIL no_residual_immunity got hit=%b x=%0d exp 10 316", hit_joe, centerx); end
        clear_keys();
    endtask

    initial begin
        test_reset();
        test_run_right();
        test_clamp_left();
        test_key_priority();
        test_fly_immunity();
        test_reset_mid_fly();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
